// File: rtl/load_pkg.sv
// rtl/load_pkg.sv - load type codes, FSM states and lane helpers shared by load_format_unit
// Shared by load_extend and load_format_unit.
package load_pkg;

   localparam int BYTE_W = 8;

   localparam logic [2:0] LT_LB  = 3'b000;
   localparam logic [2:0] LT_LH  = 3'b001;
   localparam logic [2:0] LT_LW  = 3'b010;
   localparam logic [2:0] LT_LBU = 3'b100;
   localparam logic [2:0] LT_LHU = 3'b101;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD0  = 3'd1,
      S_CAP0 = 3'd2,
      S_CAP1 = 3'd3,
      S_RESP = 3'd4
   } state_t;

   function automatic logic type_valid(input logic [2:0] t);
      return (t == LT_LB) || (t == LT_LH) || (t == LT_LW) || (t == LT_LBU) || (t == LT_LHU);
   endfunction

   function automatic logic is_half(input logic [2:0] t);
      return (t == LT_LH) || (t == LT_LHU);
   endfunction

   function automatic logic misaligned(input logic [2:0] t, input logic [1:0] off);
      return (is_half(t) && off[0]) || ((t == LT_LW) && (off != 2'b00));
   endfunction

   // A load crosses into the next word when its last byte lies beyond lane 3.
   function automatic logic crossing(input logic [2:0] t, input logic [1:0] off);
      return (is_half(t) && (off == 2'b11)) || ((t == LT_LW) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - sign/zero extension of a right-justified load lane
// Purely combinational; unknown load types yield zero.
module load_extend
   import load_pkg::*;
(
   input  logic [31:0] lane,
   input  logic [2:0]  load_type,
   output logic [31:0] data
);

   always_comb begin
      data = 32'h0;
      case (load_type)
         LT_LB:   data = {{(32-BYTE_W){lane[BYTE_W-1]}}, lane[BYTE_W-1:0]};
         LT_LBU:  data = {{(32-BYTE_W){1'b0}}, lane[BYTE_W-1:0]};
         LT_LH:   data = {{(32-2*BYTE_W){lane[2*BYTE_W-1]}}, lane[2*BYTE_W-1:0]};
         LT_LHU:  data = {{(32-2*BYTE_W){1'b0}}, lane[2*BYTE_W-1:0]};
         LT_LW:   data = lane;
         default: data = 32'h0;
      endcase
   end

endmodule

// File: rtl/load_format_unit.sv
// rtl/load_format_unit.sv - load request FSM: word reads, lane extraction and extension
// Build option LOAD_UNALIGNED_EN: misaligned loads become legal, word-crossing loads take two reads.
module load_format_unit
   import load_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              ReqValid,
   output logic              ReqReady,
   input  logic [2:0]        LoadType,
   input  logic [ADDR_W-1:0] Addr,
   output logic              MemReadEn,
   output logic [ADDR_W-1:0] MemAddr,
   input  logic [31:0]       MemRdata,
   output logic              RespValid,
   output logic [31:0]       RespData,
   output logic              LoadErr
);

   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        type_q;
   logic              cross_q;
   logic [31:0]       word0;
   logic              req_err;
   logic [55:0]       pair;
   logic [31:0]       lane;
   logic [31:0]       ext_data;

   always_comb begin
`ifdef LOAD_UNALIGNED_EN
      req_err = !type_valid(LoadType);
`else
      req_err = !type_valid(LoadType) || misaligned(LoadType, Addr[1:0]);
`endif
   end

   // In CAP1 the second word arrives on MemRdata while the first sits in word0.
   always_comb begin
      pair = (state == S_CAP1) ? {MemRdata[23:0], word0} : {24'h0, MemRdata};
      case (addr_q[1:0])
         2'd0:    lane = pair[31:0];
         2'd1:    lane = pair[39:8];
         2'd2:    lane = pair[47:16];
         default: lane = pair[55:24];
      endcase
   end

   load_extend u_extend (
      .lane      (lane),
      .load_type (type_q),
      .data      (ext_data)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= S_IDLE;
         ReqReady  <= 1'b1;
         MemReadEn <= 1'b0;
         MemAddr   <= '0;
         RespValid <= 1'b0;
         RespData  <= 32'h0;
         LoadErr   <= 1'b0;
         addr_q    <= '0;
         type_q    <= 3'b000;
         cross_q   <= 1'b0;
         word0     <= 32'h0;
      end else begin
         MemReadEn <= 1'b0;
         MemAddr   <= '0;
         RespValid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (ReqValid && ReqReady) begin
                  addr_q   <= Addr;
                  type_q   <= LoadType;
                  cross_q  <= crossing(LoadType, Addr[1:0]);
                  ReqReady <= 1'b0;
                  if (req_err) begin
                     state     <= S_RESP;
                     RespValid <= 1'b1;
                     RespData  <= 32'h0;
                     LoadErr   <= 1'b1;
                  end else begin
                     state     <= S_RD0;
                     MemReadEn <= 1'b1;
                     MemAddr   <= {Addr[ADDR_W-1:2], 2'b00};
                  end
               end
            end
            S_RD0: begin
               state <= S_CAP0;
               if (cross_q) begin
                  MemReadEn <= 1'b1;
                  MemAddr   <= {addr_q[ADDR_W-1:2], 2'b00} + ADDR_W'(4);
               end
            end
            S_CAP0: begin
               word0 <= MemRdata;
               if (cross_q) begin
                  state <= S_CAP1;
               end else begin
                  state     <= S_RESP;
                  RespValid <= 1'b1;
                  RespData  <= ext_data;
                  LoadErr   <= 1'b0;
               end
            end
            S_CAP1: begin
               state     <= S_RESP;
               RespValid <= 1'b1;
               RespData  <= ext_data;
               LoadErr   <= 1'b0;
            end
            S_RESP: begin
               state    <= S_IDLE;
               ReqReady <= 1'b1;
            end
            default: begin
               state    <= S_IDLE;
               ReqReady <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_format_unit.sv
// tb/tb_load_format_unit.sv - self-checking bench for load_format_unit
// Byte-level memory model predicts data, error flag, latency and read addresses.
module tb_load_format_unit;

   logic        Clk;
   logic        Reset;
   logic        ReqValid;
   logic        ReqReady;
   logic [2:0]  LoadType;
   logic [31:0] Addr;
   logic        MemReadEn;
   logic [31:0] MemAddr;
   logic [31:0] MemRdata;
   logic        RespValid;
   logic [31:0] RespData;
   logic        LoadErr;

   int checks;
   int failures;
   int bad_rd;
   int bad_addr;

   logic [31:0] mem_ovr [logic [31:0]];
   logic [31:0] reads [$];
   logic        pend_v;
   logic [31:0] pend_a;

   load_format_unit #(.ADDR_W(32)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .ReqValid  (ReqValid),
      .ReqReady  (ReqReady),
      .LoadType  (LoadType),
      .Addr      (Addr),
      .MemReadEn (MemReadEn),
      .MemAddr   (MemAddr),
      .MemRdata  (MemRdata),
      .RespValid (RespValid),
      .RespData  (RespData),
      .LoadErr   (LoadErr)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [31:0] mem_word(input logic [31:0] w);
      if (mem_ovr.exists(w)) return mem_ovr[w];
      return (w * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      logic [31:0] w;
      w = mem_word(a & 32'hFFFF_FFFC);
      return 8'((w >> (8 * (a % 4))) & 32'hFF);
   endfunction

   // Memory answers one cycle after a read strobe; otherwise it shows junk.
   always @(negedge Clk) begin
      MemRdata = pend_v ? mem_word(pend_a) : $urandom;
      pend_v   = MemReadEn;
      pend_a   = MemAddr;
      if (MemReadEn) reads.push_back(MemAddr);
      if (MemReadEn && (ReqReady || RespValid)) bad_rd++;
      if (!MemReadEn && MemAddr != 32'h0) bad_addr++;
      if (MemAddr[1:0] != 2'b00) bad_addr++;
   end

   function automatic void model(input logic [2:0] t, input logic [31:0] a,
                                 output logic [31:0] d, output bit e, output int lat,
                                 output int nreads, output logic [31:0] r0, output logic [31:0] r1);
      int size;
      bit mis;
      case (t)
         3'b000, 3'b100: size = 1;
         3'b001, 3'b101: size = 2;
         3'b010:         size = 4;
         default:        size = 0;
      endcase
      mis = (size != 0) && ((a % size) != 0);
`ifdef LOAD_UNALIGNED_EN
      e = (size == 0);
`else
      e = (size == 0) || mis;
`endif
      d = 32'h0; r0 = a & 32'hFFFF_FFFC; r1 = r0 + 4;
      if (e) begin
         lat = 1; nreads = 0;
      end else begin
         for (int i = 0; i < size; i++) d = d | (32'(mem_byte(a + i)) << (8 * i));
         if (t == 3'b000 && d[7])  d = d | 32'hFFFF_FF00;
         if (t == 3'b001 && d[15]) d = d | 32'hFFFF_0000;
         nreads = (((a % 4) + size) > 4) ? 2 : 1;
         lat = 2 + nreads;
      end
   endfunction

   task automatic run_load(input logic [2:0] t, input logic [31:0] a, input bit keep,
                           output logic [31:0] got_data, output logic got_err);
      logic [31:0] exp_d, r0, r1;
      bit exp_e, seen;
      int exp_lat, nreads, k;
      model(t, a, exp_d, exp_e, exp_lat, nreads, r0, r1);
      got_data = 32'h0; got_err = 1'b0;
      LoadType = t; Addr = a; ReqValid = 1'b1;
      k = 0;
      while (!ReqReady && k < 10) begin @(negedge Clk); k++; end
      checks++;
      if (!ReqReady) begin
         failures++;
         $display("FAIL accept_timeout type=%0d addr=%h ready=%b required=1", t, a, ReqReady);
         ReqValid = 1'b0;
         return;
      end
      reads.delete();
      seen = 0; k = 0;
      while (k < 8 && !seen) begin
         @(negedge Clk);
         k++;
         if (k == 1) begin
            checks++;
            if (ReqReady !== 1'b0) begin
               failures++;
               $display("FAIL ready_after_accept got=%b required=0", ReqReady);
            end
            if (!keep) ReqValid = 1'b0;
         end
         if (RespValid) seen = 1;
      end
      got_data = RespData; got_err = LoadErr;
      checks++;
      if (!seen || k != exp_lat) begin
         failures++;
         $display("FAIL latency type=%0d addr=%h got=%0d seen=%0d required=%0d", t, a, k, seen, exp_lat);
      end
      checks++;
      if (RespData !== exp_d || LoadErr !== exp_e) begin
         failures++;
         $display("FAIL resp type=%0d addr=%h data=%h err=%b required data=%h err=%b",
                  t, a, RespData, LoadErr, exp_d, exp_e);
      end
      checks++;
      if (reads.size() != nreads || (nreads > 0 && reads[0] !== r0) || (nreads > 1 && reads[1] !== r1)) begin
         failures++;
         $display("FAIL reads type=%0d addr=%h count=%0d required=%0d first=%h", t, a,
                  reads.size(), nreads, (reads.size() > 0) ? reads[0] : 32'h0);
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1; ReqValid = 1'b1; LoadType = 3'b010; Addr = 32'h0;
      @(negedge Clk); @(negedge Clk);
      checks++;
      if (ReqReady !== 1'b1 || MemReadEn !== 1'b0 || MemAddr !== 32'h0 ||
          RespValid !== 1'b0 || RespData !== 32'h0 || LoadErr !== 1'b0) begin
         failures++;
         $display("FAIL reset_state ready=%b rd=%b maddr=%h rv=%b data=%h err=%b required 1 0 0 0 0 0",
                  ReqReady, MemReadEn, MemAddr, RespValid, RespData, LoadErr);
      end
      ReqValid = 1'b0; Reset = 1'b0;
      @(negedge Clk);
   endtask

   task automatic test_directed_bytes();
      logic [31:0] d; logic e;
      mem_ovr[32'h100] = 32'h12F45678;
      run_load(3'b000, 32'h102, 0, d, e);
      checks++;
      if (d !== 32'hFFFF_FFF4 || e !== 1'b0) begin
         failures++; $display("FAIL lb_0x102 got=%h err=%b required=fffffff4 err=0", d, e);
      end
      run_load(3'b100, 32'h102, 0, d, e);
      checks++;
      if (d !== 32'h0000_00F4) begin
         failures++; $display("FAIL lbu_0x102 got=%h required=000000f4", d);
      end
      run_load(3'b101, 32'h100, 0, d, e);
      checks++;
      if (d !== 32'h0000_5678) begin
         failures++; $display("FAIL lhu_0x100 got=%h required=00005678", d);
      end
      run_load(3'b001, 32'h102, 0, d, e);
      checks++;
      if (d !== 32'h0000_12F4) begin
         failures++; $display("FAIL lh_0x102 got=%h required=000012f4", d);
      end
   endtask

   task automatic test_crossing();
      logic [31:0] d; logic e;
      mem_ovr[32'h100] = 32'hAABBCCDD;
      mem_ovr[32'h104] = 32'h11223344;
      run_load(3'b010, 32'h103, 0, d, e);
      checks++;
`ifdef LOAD_UNALIGNED_EN
      if (d !== 32'h223344AA || e !== 1'b0) begin
         failures++; $display("FAIL lw_0x103 got=%h err=%b required=223344aa err=0", d, e);
      end
`else
      if (d !== 32'h0 || e !== 1'b1) begin
         failures++; $display("FAIL lw_0x103 got=%h err=%b required=00000000 err=1", d, e);
      end
`endif
   endtask

   task automatic test_invalid_type();
      logic [31:0] d; logic e;
      run_load(3'b011, 32'h100, 0, d, e);
      checks++;
      if (d !== 32'h0 || e !== 1'b1) begin
         failures++; $display("FAIL invalid_type got=%h err=%b required=00000000 err=1", d, e);
      end
   endtask

   task automatic test_hold();
      logic [31:0] d; logic e;
      bit changed;
      run_load(3'b000, 32'h102, 0, d, e);
      changed = 0;
      repeat (4) begin
         @(negedge Clk);
         if (RespData !== d || LoadErr !== e || RespValid !== 1'b0) changed = 1;
      end
      checks++;
      if (changed) begin
         failures++; $display("FAIL hold data=%h err=%b required data=%h err=%b rv=0", RespData, LoadErr, d, e);
      end
   endtask

   task automatic test_mid_reset();
      logic [31:0] d; logic e;
      bit stray;
      mem_ovr[32'h200] = 32'hCAFEF00D;
      LoadType = 3'b010; Addr = 32'h200; ReqValid = 1'b1;
      @(negedge Clk);
      ReqValid = 1'b0;
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      checks++;
      if (ReqReady !== 1'b1 || RespValid !== 1'b0 || MemReadEn !== 1'b0 || RespData !== 32'h0) begin
         failures++;
         $display("FAIL mid_reset ready=%b rv=%b rd=%b data=%h required 1 0 0 0", ReqReady, RespValid, MemReadEn, RespData);
      end
      Reset = 1'b0;
      stray = 0;
      repeat (5) begin
         @(negedge Clk);
         if (RespValid) stray = 1;
      end
      checks++;
      if (stray) begin
         failures++; $display("FAIL mid_reset_stray_resp got=1 required=0");
      end
      run_load(3'b000, 32'h102, 0, d, e);
   endtask

   task automatic test_back_to_back();
      logic [31:0] d; logic e;
      for (int i = 0; i < 12; i++)
         run_load(3'($urandom_range(0, 7)), (32'h300 + 32'($urandom_range(0, 15))), 1, d, e);
      ReqValid = 1'b0;
      @(negedge Clk);
   endtask

   task automatic test_random();
      logic [31:0] d; logic e;
      for (int i = 0; i < 40; i++)
         run_load(3'($urandom_range(0, 7)), (($urandom & 32'h0000_0FFC) | 32'($urandom_range(0, 3))), 0, d, e);
   endtask

   task automatic test_bus_rules();
      checks++;
      if (bad_rd != 0) begin
         failures++; $display("FAIL read_in_idle_or_resp got=%0d required=0", bad_rd);
      end
      checks++;
      if (bad_addr != 0) begin
         failures++; $display("FAIL memaddr_rules got=%0d required=0", bad_addr);
      end
   endtask

   initial begin
      checks = 0; failures = 0; bad_rd = 0; bad_addr = 0;
      pend_v = 1'b0; pend_a = 32'h0;
      Reset = 1'b1; ReqValid = 1'b0; LoadType = 3'b000; Addr = 32'h0; MemRdata = 32'h0;
      test_reset();
      test_directed_bytes();
      test_crossing();
      test_invalid_type();
      test_hold();
      test_mid_reset();
      test_back_to_back();
      test_random();
      test_bus_rules();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
